// File: rtl/rx_symbol_framer.sv
// RMII/MII receive framer: preamble/SFD hunt, LSB-first byte assembly, SOF/EOF/length/error reporting.
// Optional FCS checking is built when RX_CRC_CHECK_EN is defined; otherwise crc_err_o is tied to 0.
module rx_symbol_framer #(
  parameter int unsigned SYM_W     = 2,
  parameter int unsigned MAX_BYTES = 1522,
  parameter int unsigned LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] rx_d,
  input  logic             crs_dv,
  input  logic             rx_er,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic [LEN_W-1:0] len_o,
  output logic             err_o,
  output logic             crc_err_o
);

  localparam int unsigned SPB  = 8 / SYM_W;
  localparam int unsigned PH_W = 2;
  localparam logic [7:0]  SFD  = 8'hD5;

  generate
    if (SYM_W != 2 && SYM_W != 4) begin : g_bad_sym_w
      $error("rx_symbol_framer: SYM_W must be 2 or 4");
    end
    if ((MAX_BYTES >> LEN_W) != 0) begin : g_bad_len_w
      $error("rx_symbol_framer: LEN_W too narrow for MAX_BYTES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state;
  logic [7:0]       sr;
  logic [7:0]       next_sr;
  logic [PH_W-1:0]  phase;
  logic [LEN_W-1:0] count;
  logic             sticky;
  logic             first;
  logic             crc_bad;

  // Newest symbol enters at the top so the byte ends up LSB-first.
  assign next_sr = {rx_d, sr[7:SYM_W]};

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Running the FCS through the register leaves a fixed residue on a good frame.
  assign crc_bad = (crc != 32'hDEBB20E3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 32'hFFFFFFFF;
    end else if (state == PREAMBLE && crs_dv && !rx_er && next_sr == SFD) begin
      crc <= 32'hFFFFFFFF;
    end else if (state == DATA && crs_dv && phase == PH_W'(SPB - 1) &&
                 count < LEN_W'(MAX_BYTES)) begin
      crc <= crc_next(crc, next_sr);
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= 8'h00;
      phase     <= '0;
      count     <= '0;
      sticky    <= 1'b0;
      first     <= 1'b0;
      data_o    <= 8'h00;
      valid_o   <= 1'b0;
      sof_o     <= 1'b0;
      eof_o     <= 1'b0;
      len_o     <= '0;
      err_o     <= 1'b0;
      crc_err_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
      if (crs_dv) sr <= next_sr;
      case (state)
        IDLE: begin
          if (crs_dv) state <= PREAMBLE;
        end
        PREAMBLE: begin
          if (!crs_dv) begin
            state <= IDLE;
          end else if (rx_er) begin
            state <= DROP;
          end else if (next_sr == SFD) begin
            state  <= DATA;
            phase  <= '0;
            count  <= '0;
            sticky <= 1'b0;
            first  <= 1'b1;
          end
        end
        DATA: begin
          if (!crs_dv) begin
            state     <= IDLE;
            eof_o     <= 1'b1;
            len_o     <= count;
            err_o     <= sticky | (phase != '0) | crc_bad;
            crc_err_o <= crc_bad;
          end else begin
            if (rx_er) sticky <= 1'b1;
            if (phase == PH_W'(SPB - 1)) begin
              phase <= '0;
              // Bytes beyond the length limit are dropped but flag the frame.
              if (count < LEN_W'(MAX_BYTES)) begin
                valid_o <= 1'b1;
                data_o  <= next_sr;
                sof_o   <= first;
                first   <= 1'b0;
                count   <= count + LEN_W'(1);
              end else begin
                sticky <= 1'b1;
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        DROP: begin
          if (!crs_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_symbol_framer.sv
// Bench for rx_symbol_framer: RMII, MII and length-limited instances against a frame-level reference model.
module tb_rx_symbol_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rx_a, rx_c;
  logic [3:0] rx_b;
  logic       dv [3];
  logic       er [3];
  logic [7:0] dat [3];
  logic       vld [3], sof [3], eof [3], err [3], crc [3];
  logic [10:0] len [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_symbol_framer #(.SYM_W(2), .MAX_BYTES(1522), .LEN_W(11)) u_rmii (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_a), .crs_dv(dv[0]), .rx_er(er[0]),
    .data_o(dat[0]), .valid_o(vld[0]), .sof_o(sof[0]), .eof_o(eof[0]),
    .len_o(len[0]), .err_o(err[0]), .crc_err_o(crc[0]));

  rx_symbol_framer #(.SYM_W(4), .MAX_BYTES(1522), .LEN_W(11)) u_mii (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_b), .crs_dv(dv[1]), .rx_er(er[1]),
    .data_o(dat[1]), .valid_o(vld[1]), .sof_o(sof[1]), .eof_o(eof[1]),
    .len_o(len[1]), .err_o(err[1]), .crc_err_o(crc[1]));

  rx_symbol_framer #(.SYM_W(2), .MAX_BYTES(4), .LEN_W(11)) u_short (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_c), .crs_dv(dv[2]), .rx_er(er[2]),
    .data_o(dat[2]), .valid_o(vld[2]), .sof_o(sof[2]), .eof_o(eof[2]),
    .len_o(len[2]), .err_o(err[2]), .crc_err_o(crc[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observed output events
  logic [7:0] got_b[$];
  bit         got_s[$];
  int         got_k[$];
  int         got_t[$];
  logic [10:0] got_len[$];
  bit         got_err[$];
  bit         got_crc[$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] === 1'b1) begin
        got_b.push_back(dat[k]);
        got_s.push_back(sof[k]);
        got_k.push_back(k);
        got_t.push_back(cyc);
      end
      if (eof[k] === 1'b1) begin
        got_len.push_back(len[k]);
        got_err.push_back(err[k]);
        got_crc.push_back(crc[k]);
      end
      if (vld[k] === 1'b1 && eof[k] === 1'b1) check("valid_eof_overlap", 1, 0);
    end
  end

  // Wire bit stream of the current frame, earliest bit first
  bit         bq[$];
  logic [7:0] exp_b[$];
  bit         exp_eof;
  int         exp_len;
  bit         exp_err, exp_crc;

  function automatic logic [31:0] crc32(input logic [7:0] d[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit sfd_ends_at(input int endbit);
    logic [7:0] sfd = 8'hD5;
    for (int j = 0; j < 8; j++) begin
      int idx = endbit - 8 + j;
      bit b = (idx < 0) ? 1'b0 : bq[idx];
      if (b != sfd[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Frame-level reference: find SFD, slice the rest into bytes, apply limit and error rules.
  task automatic model(input int w, input int maxb, input int er_sym);
    int nsym = bq.size() / w;
    int sfd_sym = -1;
    int start, ndbits, nbytes, deliver;
    exp_b.delete();
    exp_eof = 0; exp_len = 0; exp_err = 0; exp_crc = 0;
    for (int i = 1; i < nsym; i++) begin
      if (i == er_sym) return;
      if (sfd_ends_at((i + 1) * w)) begin sfd_sym = i; break; end
    end
    if (sfd_sym < 0) return;
    start   = (sfd_sym + 1) * w;
    ndbits  = bq.size() - start;
    nbytes  = ndbits / 8;
    deliver = (nbytes < maxb) ? nbytes : maxb;
    for (int j = 0; j < deliver; j++) begin
      logic [7:0] v = 8'h00;
      for (int b = 0; b < 8; b++) v[b] = bq[start + 8 * j + b];
      exp_b.push_back(v);
    end
`ifdef RX_CRC_CHECK_EN
    if (deliver < 4) exp_crc = 1;
    else exp_crc = (crc32(exp_b, deliver - 4) !=
                    {exp_b[deliver-1], exp_b[deliver-2], exp_b[deliver-3], exp_b[deliver-4]});
`endif
    exp_eof = 1;
    exp_len = deliver;
    exp_err = (er_sym > sfd_sym) || (ndbits % 8 != 0) || (nbytes > maxb) || exp_crc;
  endtask

  task automatic drive(input int k, input logic [3:0] sym, input logic d, input logic e);
    case (k)
      0: rx_a = sym[1:0];
      1: rx_b = sym;
      default: rx_c = sym[1:0];
    endcase
    dv[k] = d;
    er[k] = e;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_b.delete(); got_s.delete(); got_k.delete(); got_t.delete();
    got_len.delete(); got_err.delete(); got_crc.delete();
  endtask

  task automatic run_frame(input int k, input int npre, input logic [7:0] pl[$],
                           input int extra, input int er_sym);
    int w = (k == 1) ? 4 : 2;
    int maxb = (k == 2) ? 4 : 1522;
    int nsym, n;
    bq.delete();
    for (int i = 0; i < npre; i++) for (int b = 0; b < 8; b++) bq.push_back(b % 2 == 0);
    for (int b = 0; b < 8; b++) bq.push_back((8'hD5 >> b) & 1);
    foreach (pl[i]) for (int b = 0; b < 8; b++) bq.push_back(pl[i][b]);
    for (int i = 0; i < extra * w; i++) bq.push_back($urandom_range(0, 1));
    model(w, maxb, er_sym);
    clear_got();
    nsym = bq.size() / w;
    for (int i = 0; i < nsym; i++) begin
      logic [3:0] sym = 4'h0;
      for (int b = 0; b < w; b++) sym[b] = bq[i * w + b];
      drive(k, sym, 1'b1, i == er_sym);
    end
    repeat (4) drive(k, 4'h0, 1'b0, 1'b0);
    check("nbytes", got_b.size(), exp_b.size());
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int j = 0; j < n; j++) begin
      check("byte", got_b[j], exp_b[j]);
      check("sof", got_s[j], (j == 0));
      check("inst", got_k[j], k);
      if (j > 0) check("spacing", got_t[j] - got_t[j-1], 8 / w);
    end
    check("neof", got_len.size(), exp_eof);
    if (got_len.size() == 1 && exp_eof) begin
      check("len", got_len[0], exp_len);
      check("err", got_err[0], exp_err);
      check("crc_err", got_crc[0], exp_crc);
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    rst_n = 1'b0;
    rx_a = '0; rx_b = '0; rx_c = '0;
    for (int k = 0; k < 3; k++) begin dv[k] = 1'b0; er[k] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_data", dat[k], 0);
      check("rst_valid", vld[k], 0);
      check("rst_sof", sof[k], 0);
      check("rst_eof", eof[k], 0);
      check("rst_len", len[k], 0);
      check("rst_err", err[k], 0);
      check("rst_crc", crc[k], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    pl = '{8'h01, 8'h02, 8'h03};
    run_frame(0, 7, pl, 0, -1);
    run_frame(1, 7, pl, 0, -1);
    run_frame(0, 7, pl, 0, 8 * 4 + 5);      // error during 2nd payload byte
    run_frame(0, 7, pl, 0, 5);              // error in preamble
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_frame(2, 7, pl, 0, -1);             // over length limit
    run_frame(0, 7, pl, 1, -1);             // one dibit past a byte boundary
    pl.delete();
    run_frame(0, 7, pl, 0, -1);             // empty frame

    // Reset pulse mid-frame with carrier held: abandon, no eof, silent until next SFD
    clear_got();
    for (int i = 0; i < 7 * 4; i++) drive(0, 4'h1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 4'((8'hD5 >> (2 * i)) & 3), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 4'((8'hA1 >> (2 * i)) & 3), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 4'((8'hB2 >> (2 * i)) & 3), 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(0, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("midrst_data", dat[0], 0);
    check("midrst_len", len[0], 0);
    for (int i = 0; i < 12; i++) drive(0, 4'h0, 1'b1, 1'b0);
    repeat (4) drive(0, 4'h0, 1'b0, 1'b0);
    check("midrst_nbytes", got_b.size(), 2);
    if (got_b.size() == 2) begin
      check("midrst_b0", got_b[0], 8'hA1);
      check("midrst_b1", got_b[1], 8'hB2);
    end
    check("midrst_neof", got_len.size(), 0);
    pl = '{8'h01, 8'h02, 8'h03};
    run_frame(0, 7, pl, 0, -1);

`ifdef RX_CRC_CHECK_EN
    begin
      logic [31:0] f;
      pl.delete();
      for (int i = 0; i < 60; i++) pl.push_back(8'($urandom));
      f = crc32(pl, 60);
      pl.push_back(f[7:0]); pl.push_back(f[15:8]); pl.push_back(f[23:16]); pl.push_back(f[31:24]);
      run_frame(0, 7, pl, 0, -1);
      run_frame(1, 7, pl, 0, -1);
      pl[10] ^= 8'h04;
      run_frame(0, 7, pl, 0, -1);
    end
`endif

    // Randomized frames across all three instances
    for (int t = 0; t < 45; t++) begin
      int k = t % 3;
      int w = (k == 1) ? 4 : 2;
      int npre = $urandom_range(2, 7);
      int np = $urandom_range(0, (k == 2) ? 7 : 10);
      int extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8 / w - 1) : 0;
      int nsym = ((npre + 1 + np) * 8) / w + extra;
      int er_sym = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nsym - 1) : -1;
      pl.delete();
      for (int i = 0; i < np; i++) pl.push_back(8'($urandom));
      run_frame(k, npre, pl, extra, er_sym);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
